// File: rtl/up3_loader_pkg.sv
// Shared types and constants for the up3 program loader.
// State encodings double as the board-debug State output.
package up3_loader_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CSUM = 3'd3,
    ST_RDBK = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } ld_state_e;

endpackage

// File: rtl/up3_ld_cksum.sv
// Modulo-256 byte accumulator with synchronous clear (priority) and add enable.
module up3_ld_cksum
  import up3_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_val,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_val;
    end
  end

endmodule

// File: rtl/up3_loader.sv
// Streams a length-prefixed, checksummed program image into the up3 RAM,
// reads it back for verification, then releases the processor from reset.
module up3_loader
  import up3_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        State
);

  ld_state_e         state, state_nxt;
  logic [LEN_W-1:0]  len, count;
  logic [DATA_W-1:0] sum, rsum, csum_tot, rsum_tot;
  logic              xfer, launch, last_byte, rd_last;

  assign xfer      = in_valid && in_ready;
  assign launch    = start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign last_byte = (count == len - LEN_W'(1));
  assign rd_last   = (count == len);
  assign csum_tot  = sum + in_data;
  assign rsum_tot  = rsum + mem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        done      = (state == ST_DONE);
        error     = (state == ST_ERR);
        cpu_reset = (state != ST_DONE);
        if (start) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last_byte) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = (csum_tot == '0) ? ST_RDBK : ST_ERR;
      end
      ST_RDBK: begin
        busy = 1'b1;
        if (rd_last) state_nxt = (rsum_tot == sum) ? ST_DONE : ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign State = state;

  // In RDBK, count is the cycle index: address c is presented in cycle c and
  // its data is summed in cycle c+1, so cycle N only absorbs the last sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len         <= '0;
      count       <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) count <= '0;
        end
        ST_LEN: begin
          if (xfer) begin
            len   <= (in_data == '0) ? LEN_W'(256) : {1'b0, in_data};
            count <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            mem_address <= count[ADDR_W-1:0];
            mem_data    <= in_data;
            mem_wren    <= 1'b1;
            count       <= count + LEN_W'(1);
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            count       <= '0;
            mem_address <= '0;
          end
        end
        ST_RDBK: begin
          if (!rd_last) begin
            count <= count + LEN_W'(1);
            if (count + LEN_W'(1) < len) mem_address <= count[ADDR_W-1:0] + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  up3_ld_cksum u_sum (
    .clk     (clk),
    .rst     (reset),
    .clr     (launch),
    .add_en  ((state == ST_LOAD) && xfer),
    .add_val (in_data),
    .sum     (sum)
  );

  up3_ld_cksum u_rsum (
    .clk     (clk),
    .rst     (reset),
    .clr     (launch),
    .add_en  ((state == ST_RDBK) && (count != '0)),
    .add_val (mem_q),
    .sum     (rsum)
  );

endmodule

// File: tb/tb_up3_loader.sv
// Self-checking bench for up3_loader: behavioural RAM, write/readback monitor,
// and a stream-level reference model predicting outcome, writes and RDBK length.
module tb_up3_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] mem_q = 8'h00;
  logic [7:0] mem_address, mem_data;
  logic       mem_wren, cpu_reset, busy, done, error;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;

  bit [7:0]  ram [256];
  bit        ram_corrupt = 1'b0;
  bit [15:0] wr_q [$];
  int        rdbk_cycles = 0;
  bit [7:0]  stream [$];

  up3_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_q       (mem_q),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .State       (State)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= (ram_corrupt && mem_address == 8'h01) ? 8'h00 : ram[mem_address];
  end

  always @(negedge clk) begin
    if (mem_wren) wr_q.push_back({mem_address, mem_data});
    if (State == 3'd4) rdbk_cycles++;
  end

  task automatic send_byte(input bit [7:0] b, output bit ok);
    int unsigned n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!ok && n < 20) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Drives the global stream and checks the outcome predicted from stream rules.
  task automatic run_load(input string name, input bit corrupt, input bit gaps, input bit poke);
    int unsigned n, dsum, rbsum, exp_rdbk, zero_wr, w, wbase, rbase, bad_k;
    bit          csum_ok, exp_done, ok, wr_bad;
    bit [2:0]    exp_state;
    bit [15:0]   exp_w;
    n = (stream[0] == 8'h00) ? 256 : int'(stream[0]);
    dsum = 0;
    rbsum = 0;
    for (int k = 0; k < n; k++) begin
      dsum  += stream[1+k];
      rbsum += (corrupt && k == 1) ? 0 : int'(stream[1+k]);
    end
    csum_ok   = ((dsum + stream[n+1]) % 256) == 0;
    exp_done  = csum_ok && ((rbsum % 256) == (dsum % 256));
    exp_state = exp_done ? 3'd5 : 3'd6;
    exp_rdbk  = csum_ok ? n + 1 : 0;
    ram_corrupt = corrupt;
    wbase = wr_q.size();
    rbase = rdbk_cycles;

    pulse_start();
    send_byte(stream[0], ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s len_accept: got timeout expected transfer", name); end
    for (int k = 0; k < n; k++) begin
      if (poke && k == 1) start = 1'b1;
      send_byte(stream[1+k], ok);
      start = 1'b0;
      if (!ok) begin
        checks++; errors++;
        $display("FAIL %s data_accept[%0d]: got timeout expected transfer", name, k);
      end
      if (gaps) begin
        @(negedge clk);
        checks++;
        if (mem_wren !== 1'b1) begin errors++; $display("FAIL %s pulse[%0d]: got %b expected 1", name, k, mem_wren); end
        repeat (2) begin
          @(negedge clk);
          checks++;
          if (mem_wren !== 1'b0) begin errors++; $display("FAIL %s gap_wren[%0d]: got %b expected 0", name, k, mem_wren); end
        end
      end
    end
    send_byte(stream[n+1], ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s csum_accept: got timeout expected transfer", name); end

    w = 0;
    while (!(done === 1'b1 || error === 1'b1) && w < 700) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);

    checks++;
    if (State !== exp_state) begin errors++; $display("FAIL %s state: got %0d expected %0d", name, State, exp_state); end
    checks++;
    if (done !== exp_done) begin errors++; $display("FAIL %s done: got %b expected %b", name, done, exp_done); end
    checks++;
    if (error !== !exp_done) begin errors++; $display("FAIL %s error: got %b expected %b", name, error, !exp_done); end
    checks++;
    if (cpu_reset !== !exp_done) begin errors++; $display("FAIL %s cpu_reset: got %b expected %b", name, cpu_reset, !exp_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", name, busy); end
    checks++;
    if (wr_q.size() - wbase != n) begin
      errors++; $display("FAIL %s write_count: got %0d expected %0d", name, wr_q.size() - wbase, n);
    end
    wr_bad = 1'b0;
    bad_k = 0;
    zero_wr = 0;
    for (int k = 0; k < n && (wbase + k) < wr_q.size(); k++) begin
      exp_w = {k[7:0], stream[1+k]};
      if (wr_q[wbase+k][15:8] == 8'h00) zero_wr++;
      if (!wr_bad && wr_q[wbase+k] !== exp_w) begin wr_bad = 1'b1; bad_k = k; end
    end
    checks++;
    if (wr_bad) begin
      errors++;
      $display("FAIL %s write[%0d]: got addr/data %h expected %h", name, bad_k,
               wr_q[wbase+bad_k], {bad_k[7:0], stream[1+bad_k]});
    end
    checks++;
    if (zero_wr != 1) begin errors++; $display("FAIL %s addr0_writes: got %0d expected 1", name, zero_wr); end
    checks++;
    if (rdbk_cycles - rbase != exp_rdbk) begin
      errors++; $display("FAIL %s rdbk_cycles: got %0d expected %0d", name, rdbk_cycles - rbase, exp_rdbk);
    end
    ram_corrupt = 1'b0;
  endtask

  task automatic nominal_stream(input bit [7:0] c);
    stream.delete();
    stream.push_back(8'h03);
    stream.push_back(8'h11);
    stream.push_back(8'h22);
    stream.push_back(8'h33);
    stream.push_back(c);
  endtask

  task automatic test_reset();
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", State); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b expected 1", cpu_reset); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", mem_wren); end
    checks++; if ({mem_address, mem_data} !== 16'h0000) begin
      errors++; $display("FAIL reset_addr_data: got %h expected 0000", {mem_address, mem_data});
    end
    checks++; if ({in_ready, busy, done, error} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {in_ready, busy, done, error});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_idle_ignores_valid();
    int unsigned base = wr_q.size();
    in_valid = 1'b1;
    in_data  = 8'h07;
    repeat (4) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b expected 0", in_ready); end
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", State); end
    checks++; if (wr_q.size() != base) begin errors++; $display("FAIL idle_writes: got %0d expected 0", wr_q.size() - base); end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic test_nominal();
    nominal_stream(8'h9A);
    run_load("nominal", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    nominal_stream(8'h00);
    run_load("bad_csum", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_len_256();
    stream.delete();
    stream.push_back(8'h00);
    for (int i = 0; i < 256; i++) stream.push_back(i[7:0]);
    stream.push_back(8'h80);
    run_load("len256", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    nominal_stream(8'h9A);
    run_load("backpressure", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_readback_fault();
    nominal_stream(8'h9A);
    run_load("rdbk_fault", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    bit ok0, ok1, ok2;
    int unsigned base;
    pulse_start();
    send_byte(8'h03, ok0);
    send_byte(8'hA5, ok1);
    send_byte(8'h5A, ok2);
    checks++;
    if (!(ok0 && ok1 && ok2)) begin errors++; $display("FAIL midrst_accept: got %b%b%b expected 111", ok0, ok1, ok2); end
    reset = 1'b1;
    #1;
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", State); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL midrst_wren: got %b expected 0", mem_wren); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL midrst_cpu_reset: got %b expected 1", cpu_reset); end
    base = wr_q.size();
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (wr_q.size() != base) begin errors++; $display("FAIL midrst_writes: got %0d expected 0", wr_q.size() - base); end
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL midrst_idle: got %0d expected 0", State); end
    nominal_stream(8'h9A);
    run_load("after_reset", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int unsigned n, s;
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 16);
      stream.delete();
      stream.push_back(n[7:0]);
      s = 0;
      for (int k = 0; k < n; k++) begin
        stream.push_back($urandom_range(0, 255));
        s += stream[1+k];
      end
      if ($urandom_range(0, 3) != 0) stream.push_back(8'((256 - (s % 256)) % 256));
      else stream.push_back($urandom_range(0, 255));
      run_load($sformatf("rand%0d", it), $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    test_reset();
    test_idle_ignores_valid();
    test_nominal();
    test_bad_checksum();
    test_len_256();
    test_backpressure();
    test_readback_fault();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
